// File: rtl/fp_addsub_arbiter.sv
// Round-robin arbiter feeding a shared fixed-latency FP add/sub datapath.
// Each issued operation carries a requester tag so its result is returned to that port only.
module fp_addsub_arbiter #(
  parameter int LAT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hold,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req0_sub,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic        req1_sub,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_data,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_data,
  output logic        fpu_issue,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  input  logic [31:0] fpu_c,
  output logic        busy
);

  logic           ptr_reg;
  logic           issue_id_reg;
  logic [LAT-1:0] tag_v_reg;
  logic [LAT-1:0] tag_id_reg;
  logic [LAT-1:0] tag_v_next;
  logic [LAT-1:0] tag_id_next;

  logic        grant;
  logic        grant_id;
  logic [31:0] sel_a;
  logic [31:0] sel_b;
  logic        sel_sub;
  logic        exit_v;
  logic        exit_id;

  // Readys are gated by rst_n so nothing is accepted while reset is held.
  assign req0_ready = rst_n & ~hold & req0_valid & (~ptr_reg | ~req1_valid);
  assign req1_ready = rst_n & ~hold & req1_valid & (ptr_reg | ~req0_valid);

  assign grant    = req0_ready | req1_ready;
  assign grant_id = req1_ready;
  assign sel_a    = grant_id ? req1_a   : req0_a;
  assign sel_b    = grant_id ? req1_b   : req0_b;
  assign sel_sub  = grant_id ? req1_sub : req0_sub;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg      <= 1'b0;
      fpu_issue    <= 1'b0;
      fpu_a        <= 32'd0;
      fpu_b        <= 32'd0;
      issue_id_reg <= 1'b0;
    end else begin
      fpu_issue <= grant;
      if (grant) begin
        ptr_reg      <= ~grant_id;
        fpu_a        <= sel_a;
        fpu_b        <= {sel_b[31] ^ sel_sub, sel_b[30:0]};
        issue_id_reg <= grant_id;
      end
    end
  end

  // Stage 0 follows the issue register, so the last stage lines up with fpu_c.
  genvar gi;
  generate
    for (gi = 0; gi < LAT; gi++) begin : g_tag
      if (gi == 0) begin : g_head
        assign tag_v_next[gi]  = fpu_issue;
        assign tag_id_next[gi] = issue_id_reg;
      end else begin : g_body
        assign tag_v_next[gi]  = tag_v_reg[gi-1];
        assign tag_id_next[gi] = tag_id_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v_reg  <= '0;
      tag_id_reg <= '0;
    end else begin
      tag_v_reg  <= tag_v_next;
      tag_id_reg <= tag_id_next;
    end
  end

  assign exit_v  = tag_v_reg[LAT-1];
  assign exit_id = tag_id_reg[LAT-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_data  <= 32'd0;
      rsp1_data  <= 32'd0;
    end else begin
      rsp0_valid <= exit_v & ~exit_id;
      rsp1_valid <= exit_v & exit_id;
      if (exit_v && !exit_id) rsp0_data <= fpu_c;
      if (exit_v && exit_id)  rsp1_data <= fpu_c;
    end
  end

  assign busy = fpu_issue | (|tag_v_reg) | rsp0_valid | rsp1_valid;

endmodule

// File: tb/tb_fp_addsub_arbiter.sv
// Bench for fp_addsub_arbiter: table vectors plus hand sequences, results checked by a scoreboard.
// The datapath is modelled as an exact LAT-cycle single-precision adder of fpu_a + fpu_b.
module tb_fp_addsub_arbiter;
  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hold;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        req0_sub, req1_sub;
  logic        rsp0_valid, rsp1_valid;
  logic [31:0] rsp0_data, rsp1_data;
  logic        fpu_issue;
  logic [31:0] fpu_a, fpu_b, fpu_c;
  logic        busy;

  fp_addsub_arbiter #(.LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
    .fpu_issue(fpu_issue), .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_c(fpu_c), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        port;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic        id;
    logic [31:0] data;
    int          cyc;
  } sb_t;

  vec_t vecs [8];
  vec_t s0 [$];
  vec_t s1 [$];
  sb_t  sb_q [$];
  logic grant_log [$];

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] exp0, exp1;

  // Normal numbers and zero only; the chosen operands give exact results.
  function automatic real sp2r(logic [31:0] x);
    logic [63:0] d;
    if (x[30:0] == 31'd0) d = {x[31], 63'd0};
    else d = {x[31], 11'(x[30:23]) - 11'd127 + 11'd1023, x[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2sp(real r);
    logic [63:0] d;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    return {d[63], 8'(d[62:52] - 11'd1023 + 11'd127), d[51:29]};
  endfunction

  function automatic logic [31:0] fadd(logic [31:0] a, logic [31:0] b);
    return r2sp(sp2r(a) + sp2r(b));
  endfunction

  logic [31:0] dp_pipe [LAT];
  always @(posedge clk) begin
    dp_pipe[0] <= fadd(fpu_a, fpu_b);
    for (int i = 1; i < LAT; i++) dp_pipe[i] <= dp_pipe[i-1];
  end
  assign fpu_c = dp_pipe[LAT-1];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: records grants, checks the issue register, and scores responses.
  logic        iss_pend = 1'b0;
  logic [31:0] pend_a, pend_b;
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      sb_q.delete();
      iss_pend = 1'b0;
    end else begin
      if (iss_pend) begin
        chk("fpu_issue", {31'd0, fpu_issue}, 32'd1);
        chk("fpu_a", fpu_a, pend_a);
        chk("fpu_b", fpu_b, pend_b);
      end else begin
        chk("fpu_issue_idle", {31'd0, fpu_issue}, 32'd0);
      end
      iss_pend = 1'b0;
      chk("one_ready", {31'd0, req0_ready & req1_ready}, 32'd0);
      chk("ready_wo_valid", {31'd0, (req0_ready & ~req0_valid) | (req1_ready & ~req1_valid)}, 32'd0);
      if (hold) chk("ready_in_hold", {31'd0, req0_ready | req1_ready}, 32'd0);
      if (req0_ready || req1_ready) begin
        sb_q.push_back('{id: req1_ready, data: req1_ready ? exp1 : exp0, cyc: cyc});
        grant_log.push_back(req1_ready);
        iss_pend = 1'b1;
        pend_a = req1_ready ? req1_a : req0_a;
        pend_b = req1_ready ? {req1_b[31] ^ req1_sub, req1_b[30:0]}
                            : {req0_b[31] ^ req0_sub, req0_b[30:0]};
      end
      if (rsp0_valid || rsp1_valid) begin
        chk("one_rsp", {31'd0, rsp0_valid & rsp1_valid}, 32'd0);
        if (sb_q.size() == 0) begin
          chk("unexpected_rsp", {31'd0, rsp1_valid}, 32'hFFFFFFFF);
        end else begin
          sb_t e;
          e = sb_q.pop_front();
          chk("rsp_port", {31'd0, rsp1_valid}, {31'd0, e.id});
          chk("rsp_data", rsp1_valid ? rsp1_data : rsp0_data, e.data);
          chk("rsp_latency", 32'(cyc - e.cyc), 32'(LAT + 2));
        end
      end
    end
  end

  // Drives both per-port queues until each entry has been handshaken.
  task automatic run_streams();
    int guard = 0;
    while ((s0.size() > 0 || s1.size() > 0) && guard < 100) begin
      req0_valid = (s0.size() > 0);
      req1_valid = (s1.size() > 0);
      if (s0.size() > 0) begin
        req0_a = s0[0].a; req0_b = s0[0].b; req0_sub = s0[0].sub; exp0 = s0[0].exp;
      end
      if (s1.size() > 0) begin
        req1_a = s1[0].a; req1_b = s1[0].b; req1_sub = s1[0].sub; exp1 = s1[0].exp;
      end
      @(negedge clk);
      if (req0_ready) void'(s0.pop_front());
      if (req1_ready) void'(s1.pop_front());
      @(posedge clk); #1;
      guard++;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("stream_done", {31'd0, guard < 100}, 32'd1);
  endtask

  task automatic push_vec(input vec_t v);
    if (v.port) s1.push_back(v);
    else s0.push_back(v);
  endtask

  function automatic vec_t mk(input logic port, input logic [31:0] a, input logic [31:0] b, input logic sub);
    vec_t v;
    v.port = port; v.a = a; v.b = b; v.sub = sub;
    v.exp = fadd(a, {b[31] ^ sub, b[30:0]});
    return v;
  endfunction

  task automatic check_order(input int mark, input int n, input logic first);
    chk("grant_count", 32'(grant_log.size() - mark), 32'(n));
    for (int k = 0; k < n && mark + k < grant_log.size(); k++)
      chk("grant_order", {31'd0, grant_log[mark+k]}, {31'd0, first ^ k[0]});
  endtask

  task automatic drain();
    repeat (8) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   mark;
    int   c0;
    vec_t hv0, hv1;

    vecs[0] = '{port: 1'b0, a: 32'h3F800000, b: 32'h40000000, sub: 1'b0, exp: 32'h40400000};
    vecs[1] = '{port: 1'b1, a: 32'h3FC00000, b: 32'h3F000000, sub: 1'b1, exp: 32'h3F800000};
    vecs[2] = '{port: 1'b0, a: 32'h40800000, b: 32'h3F800000, sub: 1'b0, exp: 32'h40A00000};
    vecs[3] = '{port: 1'b1, a: 32'h40000000, b: 32'h3F800000, sub: 1'b1, exp: 32'h3F800000};
    vecs[4] = '{port: 1'b0, a: 32'h3F000000, b: 32'h3F000000, sub: 1'b0, exp: 32'h3F800000};
    vecs[5] = '{port: 1'b1, a: 32'h41000000, b: 32'hC0000000, sub: 1'b0, exp: 32'h40C00000};
    vecs[6] = '{port: 1'b0, a: 32'h40400000, b: 32'h3FC00000, sub: 1'b1, exp: 32'h3FC00000};
    vecs[7] = '{port: 1'b1, a: 32'h3F800000, b: 32'h00000000, sub: 1'b0, exp: 32'h3F800000};

    rst_n = 1'b0; hold = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b0;
    req0_a = 32'h3F800000; req0_b = 32'h3F800000; req0_sub = 1'b0;
    req1_a = '0; req1_b = '0; req1_sub = 1'b0;
    exp0 = '0; exp1 = '0;
    repeat (2) @(negedge clk);
    chk("reset_ready0", {31'd0, req0_ready}, 32'd0);
    chk("reset_issue", {31'd0, fpu_issue}, 32'd0);
    chk("reset_fpu_a", fpu_a, 32'd0);
    chk("reset_fpu_b", fpu_b, 32'd0);
    chk("reset_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    chk("reset_rsp0_data", rsp0_data, 32'd0);
    chk("reset_rsp1_data", rsp1_data, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    req0_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single add
    push_vec(vecs[0]);
    run_streams();
    repeat (5) @(negedge clk);
    chk("t1_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
    chk("t1_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    chk("t1_rsp0_data", rsp0_data, 32'h40400000);
    @(negedge clk);
    chk("t1_busy_low", {31'd0, busy}, 32'd0);
    chk("t1_rsp0_pulse", {31'd0, rsp0_valid}, 32'd0);
    @(posedge clk); #1;

    // Subtract sign flip
    push_vec(vecs[1]);
    run_streams();
    @(negedge clk);
    chk("t2_fpu_b", fpu_b, 32'hBF000000);
    repeat (4) @(negedge clk);
    chk("t2_rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
    chk("t2_rsp1_data", rsp1_data, 32'h3F800000);
    chk("t2_rsp0_data_kept", rsp0_data, 32'h40400000);
    @(posedge clk); #1;

    // Contention: alternating grants from the table
    mark = grant_log.size();
    for (int i = 2; i < 8; i++) push_vec(vecs[i]);
    run_streams();
    check_order(mark, 6, 1'b0);
    drain();

    // Lone requester, then both valid
    mark = grant_log.size();
    for (int k = 0; k < 4; k++)
      push_vec(mk(1'b1, 32'h3F800000 + (32'(k) << 23), 32'h3F000000, k[0]));
    c0 = cyc;
    run_streams();
    chk("lone_cycles", 32'(cyc - c0), 32'd4);
    chk("lone_count", 32'(grant_log.size() - mark), 32'd4);
    for (int k = 0; k < 4 && mark + k < grant_log.size(); k++)
      chk("lone_port", {31'd0, grant_log[mark+k]}, 32'd1);
    mark = grant_log.size();
    push_vec(mk(1'b0, 32'h40000000, 32'h40000000, 1'b0));
    push_vec(mk(1'b1, 32'h40400000, 32'h3F800000, 1'b1));
    run_streams();
    check_order(mark, 2, 1'b0);
    drain();

    // Hold with two operations in flight
    push_vec(mk(1'b0, 32'h40A00000, 32'h3F800000, 1'b0));
    push_vec(mk(1'b1, 32'h40C00000, 32'h40000000, 1'b1));
    run_streams();
    hv0 = mk(1'b0, 32'h41000000, 32'h40000000, 1'b1);
    hv1 = mk(1'b1, 32'h3F800000, 32'h3F800000, 1'b0);
    hold = 1'b1;
    req0_valid = 1'b1; req0_a = hv0.a; req0_b = hv0.b; req0_sub = hv0.sub; exp0 = hv0.exp;
    req1_valid = 1'b1; req1_a = hv1.a; req1_b = hv1.b; req1_sub = hv1.sub; exp1 = hv1.exp;
    mark = grant_log.size();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("hold_readys", {30'd0, req1_ready, req0_ready}, 32'd0);
      chk("hold_busy", {31'd0, busy}, 32'd1);
      @(posedge clk); #1;
    end
    hold = 1'b0;
    push_vec(hv0);
    push_vec(hv1);
    run_streams();
    check_order(mark, 2, 1'b0);
    drain();

    // Reset while three operations are in flight
    push_vec(mk(1'b0, 32'h3F800000, 32'h3F800000, 1'b0));
    push_vec(mk(1'b1, 32'h40000000, 32'h3F800000, 1'b0));
    push_vec(mk(1'b0, 32'h40800000, 32'h3F800000, 1'b1));
    run_streams();
    @(posedge clk); #1;
    rst_n = 1'b0;
    req0_valid = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready0", {31'd0, req0_ready}, 32'd0);
    chk("mid_rst_issue", {31'd0, fpu_issue}, 32'd0);
    chk("mid_rst_fpu_a", fpu_a, 32'd0);
    chk("mid_rst_fpu_b", fpu_b, 32'd0);
    chk("mid_rst_rsp0_data", rsp0_data, 32'd0);
    chk("mid_rst_rsp1_data", rsp1_data, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    req0_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("post_rst_no_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
      chk("post_rst_busy", {31'd0, busy}, 32'd0);
    end
    @(posedge clk); #1;
    push_vec(mk(1'b1, 32'h40000000, 32'h40000000, 1'b1));
    run_streams();
    drain();
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
